// File: rtl/gcd_seq_if.sv
// rtl/gcd_seq_if.sv - operand/result handshake bundle for gcd_seq
// iter_cnt is present only when GCD_ITER_CNT_EN is defined.
interface gcd_seq_if #(
  parameter int WIDTH    = 16,
  parameter int MAX_ITER = 2**WIDTH
);
  localparam int CNT_W = $clog2(MAX_ITER + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] gcd_out;
  logic             err;
`ifdef GCD_ITER_CNT_EN
  logic [CNT_W-1:0] iter_cnt;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, gcd_out, err, iter_cnt
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, gcd_out, err, iter_cnt
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, gcd_out, err
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, gcd_out, err
  );
`endif
endinterface

// File: rtl/gcd_seq.sv
// rtl/gcd_seq.sv - iterative subtraction-based GCD engine, one step per clock
// Define GCD_ITER_CNT_EN to expose the final subtraction count on iter_cnt.
module gcd_seq #(
  parameter int WIDTH    = 16,
  parameter int MAX_ITER = 2**WIDTH,
  localparam int CNT_W   = $clog2(MAX_ITER + 1)
) (
  input  logic      clk,
  input  logic      rst,
  gcd_seq_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
`ifdef GCD_ITER_CNT_EN
  logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
`endif

  logic calc_done;
  logic at_cap;

  // Termination is checked before the cap so a pair finishing on the last allowed step is not flagged.
  assign calc_done = (x_q == '0) || (y_q == '0) || (x_q == y_q);
  assign at_cap    = (count_q == CNT_W'(MAX_ITER));

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    count_d     = count_q;
    gcd_d       = gcd_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
`ifdef GCD_ITER_CNT_EN
    iter_cnt_d  = iter_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          x_d     = bus.a;
          y_d     = bus.b;
          count_d = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (calc_done) begin
          gcd_d       = (x_q == '0) ? y_q : x_q;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
`ifdef GCD_ITER_CNT_EN
          iter_cnt_d  = count_q;
`endif
        end else if (at_cap) begin
          gcd_d       = '0;
          err_d       = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
`ifdef GCD_ITER_CNT_EN
          iter_cnt_d  = count_q;
`endif
        end else if (x_q > y_q) begin
          x_d     = x_q - y_q;
          count_d = count_q + CNT_W'(1);
        end else begin
          y_d     = y_q - x_q;
          count_d = count_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      count_q     <= '0;
      gcd_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef GCD_ITER_CNT_EN
      iter_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      count_q     <= count_d;
      gcd_q       <= gcd_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
`ifdef GCD_ITER_CNT_EN
      iter_cnt_q  <= iter_cnt_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.gcd_out   = gcd_q;
  assign bus.err       = err_q;
`ifdef GCD_ITER_CNT_EN
  assign bus.iter_cnt  = iter_cnt_q;
`endif

endmodule

// File: tb/tb_gcd_seq.sv
// tb/tb_gcd_seq.sv - directed bench for gcd_seq against a Euclid-by-division model
// Honours GCD_ITER_CNT_EN when checking iter_cnt.
module tb_gcd_seq;
  localparam int W    = 16;
  localparam int MAXI = 2**W;
  localparam int SW   = 8;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gcd_seq_if #(.WIDTH(W),  .MAX_ITER(MAXI)) bus ();
  gcd_seq_if #(.WIDTH(SW), .MAX_ITER(SMAX)) sbus ();

  gcd_seq #(.WIDTH(W),  .MAX_ITER(MAXI)) dut  (.clk(clk), .rst(rst), .bus(bus));
  gcd_seq #(.WIDTH(SW), .MAX_ITER(SMAX)) sdut (.clk(clk), .rst(rst), .bus(sbus));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Subtractive steps equal the sum of Euclid quotients, less the final equal-pair step.
  function automatic int model_steps(input int a, input int b);
    int hi, lo, r, sum;
    if (a == 0 || b == 0) return 0;
    hi = (a > b) ? a : b;
    lo = (a > b) ? b : a;
    sum = 0;
    while (lo != 0) begin
      sum += hi / lo;
      r = hi % lo;
      hi = lo;
      lo = r;
    end
    return sum - 1;
  endfunction

  typedef struct {
    int gcd;
    int err;
    int cnt;
    int due;
    bit seen;
    bit late;
  } exp_t;

  exp_t q[$];
  int   ncyc = 0;

  always @(negedge clk) begin
    exp_t e;
    int   n;
    ncyc++;
    if (rst) begin
      q.delete();
    end else begin
      if (q.size() != 0 && q[0].seen && !bus.out_valid) void'(q.pop_front());
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          if (!q[0].seen) begin
            check("latency", ncyc, q[0].due);
            q[0].seen = 1'b1;
          end
          check("gcd_out", bus.gcd_out, q[0].gcd);
          check("err", bus.err, q[0].err);
          check("in_ready_in_done", bus.in_ready, 0);
`ifdef GCD_ITER_CNT_EN
          check("iter_cnt", bus.iter_cnt, q[0].cnt);
`endif
        end
      end else if (q.size() != 0 && !q[0].seen && !q[0].late && ncyc > q[0].due) begin
        q[0].late = 1'b1;
        check("late_out_valid", ncyc, q[0].due);
      end
      if (bus.in_valid && bus.in_ready) begin
        n = model_steps(int'(bus.a), int'(bus.b));
        if (n > MAXI) begin
          e.gcd = 0; e.err = 1; e.cnt = MAXI; e.due = ncyc + 1 + MAXI + 1;
        end else begin
          e.gcd = model_gcd(int'(bus.a), int'(bus.b)); e.err = 0; e.cnt = n; e.due = ncyc + 1 + n + 1;
        end
        e.seen = 1'b0;
        e.late = 1'b0;
        q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int av, input int bv);
    int guard = 0;
    bus.a = W'(av);
    bus.b = W'(bv);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check("in_ready_timeout", 0, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int guard = 0;
    while (q.size() != 0 && guard < budget) begin
      tick();
      guard++;
    end
    if (guard >= budget) check("result_timeout", 0, 1);
  endtask

  task automatic small_run(input int av, input int bv, input int eg, input int ee,
                           input int ec, input int el);
    int k = 0;
    check("s_in_ready", sbus.in_ready, 1);
    sbus.a = SW'(av);
    sbus.b = SW'(bv);
    sbus.in_valid = 1'b1;
    tick();
    sbus.in_valid = 1'b0;
    while (!sbus.out_valid && k < 50) begin
      tick();
      k++;
    end
    check("s_latency", k, el);
    check("s_gcd_out", sbus.gcd_out, eg);
    check("s_err", sbus.err, ee);
`ifdef GCD_ITER_CNT_EN
    check("s_iter_cnt", sbus.iter_cnt, ec);
`else
    if (ec < 0) check("s_iter_cnt_arg", ec, 0);
`endif
    tick();
    check("s_back_idle", sbus.in_ready, 1);
  endtask

  typedef struct { int a; int b; int g; int n; } vec_t;
  vec_t vecs[$];

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    sbus.in_valid = 1'b0; sbus.a = '0; sbus.b = '0; sbus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_gcd_out", bus.gcd_out, 0);
    check("rst_err", bus.err, 0);
`ifdef GCD_ITER_CNT_EN
    check("rst_iter_cnt", bus.iter_cnt, 0);
`endif

    vecs = '{'{12, 18, 6, 2}, '{0, 25, 25, 0}, '{25, 0, 25, 0}, '{0, 0, 0, 0},
             '{48, 48, 48, 0}, '{100, 75, 25, 3}, '{13, 8, 1, 5}, '{9, 6, 3, 2},
             '{1, 65535, 1, 65534}};
    foreach (vecs[i]) begin
      check($sformatf("model_gcd_%0d_%0d", vecs[i].a, vecs[i].b),
            model_gcd(vecs[i].a, vecs[i].b), vecs[i].g);
      check($sformatf("model_n_%0d_%0d", vecs[i].a, vecs[i].b),
            model_steps(vecs[i].a, vecs[i].b), vecs[i].n);
      send(vecs[i].a, vecs[i].b);
      wait_idle(70000);
    end

    // Backpressure: result must sit untouched while new operands are offered.
    bus.out_ready = 1'b0;
    send(35, 21);
    begin
      int k = 0;
      while (!bus.out_valid && k < 50) begin
        tick();
        k++;
      end
    end
    check("bp_out_valid", bus.out_valid, 1);
    for (int i = 0; i < 6; i++) begin
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_gcd", bus.gcd_out, 7);
      check("bp_in_ready", bus.in_ready, 0);
      bus.in_valid = 1'b1;
      bus.a = 16'd100;
      bus.b = 16'd10;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_ready", bus.in_ready, 1);
    check("bp_release_valid", bus.out_valid, 0);
    wait_idle(10);

    // Reset mid-computation discards the result.
    send(1, 1000);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_gcd_out", bus.gcd_out, 0);
    check("midrst_err", bus.err, 0);
    send(9, 6);
    wait_idle(50);

    small_run(1, 100, 0, 1, SMAX, SMAX + 1);
    small_run(1, 5, 1, 0, 4, 5);
    small_run(12, 18, 6, 0, 2, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gcd_seq.md
Name: gcd_seq

Overview:
Parametrised, iterative GCD engine using subtraction-based Euclid, one subtraction step per clock.
- Operands are accepted over a valid/ready input handshake. The result is returned over a valid/ready output handshake.
- An iteration cap bounds latency. Hitting the cap raises an error flag instead of hanging.
- Serves as the registered, timing-closed successor to the combinational GCD unit in the calculator datapath.

Parameters:
WIDTH, 16, operand and result width in bits (>=2)
MAX_ITER, 2**WIDTH, maximum subtraction steps before abort; default never trips for legal inputs
CNT_W, $clog2(MAX_ITER+1), iteration counter width (derived, do not override)

Ports:
clk        input   1        clock, all logic on rising edge
rst        input   1        synchronous active-high reset
in_valid   input   1        operand pair valid
in_ready   output  1        block can accept operands
a          input   WIDTH    operand A, sampled on input handshake
b          input   WIDTH    operand B, sampled on input handshake
out_valid  output  1        result valid
out_ready  input   1        consumer accepts result
gcd_out    output  WIDTH    GCD result; 0 on error
err        output  1        iteration cap reached; qualified by out_valid
iter_cnt   output  CNT_W    subtraction steps used; present only with GCD_ITER_CNT_EN

Behaviour:
- Reset (rst=1 at rising edge):
  - State becomes IDLE.
  - in_ready=1, out_valid=0, gcd_out=0, err=0, internal x/y/count=0.
  - Reset applies in any state; an in-flight computation is discarded with no output.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: x<=a, y<=b, count<=0, go to CALC.
  - in_valid with no handshake has no effect.
- CALC (in_ready=0, out_valid=0). Priority order each cycle:
  1. If x==0 or y==0 or x==y: gcd_out<=(x==0)?y:x, err<=0, go to DONE.
  2. Else if count==MAX_ITER: gcd_out<=0, err<=1, go to DONE.
  3. Else if x>y: x<=x-y, count<=count+1. Otherwise y<=y-x, count<=count+1.
- DONE:
  - out_valid=1, in_ready=0. gcd_out and err are held stable.
  - On out_ready: go to IDLE, out_valid<=0. gcd_out/err keep their last value (don't-care).
- Latency:
  - N = number of subtraction steps.
  - out_valid rises N+1 cycles after the accepting edge.
  - Back-to-back throughput: one result per N+3 cycles with out_ready held high.
- Arithmetic: unsigned, WIDTH bits throughout. Subtraction never underflows because the larger operand is always the minuend.
- Boundary cases:
  - a=0,b=0 -> gcd_out=0, err=0.
  - a=0 -> b; b=0 -> a; a==b -> a. All with N=0.
  - Worst case for legal input is (1, 2^WIDTH-1): N=2^WIDTH-2, below the default cap.
- Simultaneous events:
  - rst dominates all handshakes.
  - in_valid during CALC/DONE is ignored and the operands are not sampled. The upstream holds them until in_ready.
- Outputs are registered; no combinational path from inputs to outputs except none (in_ready derived from state only).

Optional Feature:
GCD_ITER_CNT_EN
- Defined:
  - iter_cnt port exists and is driven by a register loaded with the final count on entry to DONE.
  - Held through DONE; reset value 0.
  - On error, iter_cnt=MAX_ITER.
- Undefined: port and register absent. All other behaviour is identical.

Test Plan:
- (12,18) handshake at cycle 0 -> out_valid high cycle 3, gcd_out=6, err=0, iter_cnt=2.
- (0,25), (25,0), (0,0), (48,48) -> results 25, 25, 0, 48. Each out_valid 1 cycle after accept, iter_cnt=0.
- (1,65535), WIDTH=16 -> gcd_out=1, err=0, iter_cnt=65534, out_valid 65535 cycles after accept.
- MAX_ITER=4, (1,100) -> out_valid 5 cycles after accept, gcd_out=0, err=1, iter_cnt=4.
- Backpressure: (35,21) completes, out_ready held 0 for 6 cycles -> out_valid, gcd_out=7 stable throughout, in_ready=0, new in_valid ignored. Release -> IDLE next cycle, in_ready=1.
- rst pulsed mid-CALC on (1,1000) -> next cycle IDLE, in_ready=1, out_valid=0, gcd_out=0. A subsequent (9,6) gives 3.
